impulse_resolver: RTL and testbench

IMPULSE_RESOLVER -- requirements
Module: impulse_resolver

---
 rtl/impulse_resolver.sv | 224 ++++++++++++++++++++++
 tb/tb_impulse_resolver.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/impulse_resolver.sv
// Impulse resolver: 2D contact impulse j = -2*vn/(ima+imb), applied along the normal.
// Ports: in_* contact handshake + Q6.26 operands, out_* result handshake, impulses,
//   Q8.24 nudges (macro IMPULSE_NUDGE_EN enables them; otherwise tied to 0), div_err.
module impulse_resolver #(
  parameter int DIV_CYCLES = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] normal_x,
  input  logic [31:0] normal_y,
  input  logic [31:0] vrel_x,
  input  logic [31:0] vrel_y,
  input  logic [31:0] inv_mass_a,
  input  logic [31:0] inv_mass_b,
  input  logic [31:0] penetration,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] imp_a_x,
  output logic [31:0] imp_a_y,
  output logic [31:0] imp_b_x,
  output logic [31:0] imp_b_y,
  output logic [31:0] nudge_a_x,
  output logic [31:0] nudge_a_y,
  output logic [31:0] nudge_b_x,
  output logic [31:0] nudge_b_y,
  output logic        div_err
);

  localparam int QW = DIV_CYCLES;
  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [2:0] {
    IDLE, DOT, DIV, MUL, DONE
  } state_t;

  state_t r_state, w_next;

  logic [31:0] r_nx, r_ny, r_vx, r_vy;
  logic [31:0] r_ima, r_imb;
  logic [32:0] r_den;
  logic [32:0] r_rem;
  logic [QW-1:0] r_dvd;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_iax, r_iay, r_ibx, r_iby;
  logic        r_err;

  logic signed [63:0] w_dot;
  logic signed [31:0] w_vn;
  logic [32:0] w_den;
  logic [32:0] w_num;
  logic        w_skip;
  logic [33:0] w_trial;
  logic        w_ge;
  logic [32:0] w_diff;
  logic [31:0] w_j;
  logic signed [63:0] w_px, w_py;
  logic [31:0] w_iax, w_iay;

  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647)
      sat32 = 32'h7FFFFFFF;
    else if (v < -64'sd2147483648)
      sat32 = 32'h80000000;
    else
      sat32 = v[31:0];
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = (v == 32'h80000000) ? 32'h7FFFFFFF : -v;
  endfunction

  assign w_dot = $signed({{32{r_vx[31]}}, r_vx}) * $signed({{32{r_nx[31]}}, r_nx})
               + $signed({{32{r_vy[31]}}, r_vy}) * $signed({{32{r_ny[31]}}, r_ny});
  assign w_vn   = 32'(w_dot >>> 26);
  assign w_den  = {1'b0, r_ima} + {1'b0, r_imb};
  assign w_skip = ~w_vn[31] | (w_den == 33'd0);
  // vn < 0 here, so -2*vn lies in (0, 2^32] and fits 33 bits
  assign w_num  = 33'(-{w_vn[31], w_vn, 1'b0});

  // restoring step: remainder stays below den, dividend slot refills with quotient
  assign w_trial = {r_rem, r_dvd[QW-1]};
  assign w_ge    = w_trial >= {1'b0, r_den};
  assign w_diff  = 33'(w_trial - {1'b0, r_den});

  assign w_j  = (|r_dvd[QW-1:31]) ? 32'h7FFFFFFF : r_dvd[31:0];
  assign w_px = $signed({32'd0, w_j}) * $signed({{32{r_nx[31]}}, r_nx});
  assign w_py = $signed({32'd0, w_j}) * $signed({{32{r_ny[31]}}, r_ny});
  assign w_iax = sat32(w_px >>> 26);
  assign w_iay = sat32(w_py >>> 26);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = DOT;
      end
      DOT: w_next = w_skip ? MUL : DIV;
      DIV: begin
        if (r_cnt == CW'(DIV_CYCLES - 1)) w_next = MUL;
      end
      MUL: w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nx  <= '0;
      r_ny  <= '0;
      r_vx  <= '0;
      r_vy  <= '0;
      r_ima <= '0;
      r_imb <= '0;
      r_den <= '0;
      r_rem <= '0;
      r_dvd <= '0;
      r_cnt <= '0;
      r_iax <= '0;
      r_iay <= '0;
      r_ibx <= '0;
      r_iby <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_nx  <= normal_x;
            r_ny  <= normal_y;
            r_vx  <= vrel_x;
            r_vy  <= vrel_y;
            r_ima <= inv_mass_a;
            r_imb <= inv_mass_b;
            r_err <= 1'b0;
          end
        end
        DOT: begin
          r_cnt <= '0;
          r_rem <= '0;
          r_den <= w_den;
          r_err <= (w_den == 33'd0);
          r_dvd <= w_skip ? '0 : QW'({w_num, 26'd0});
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_ge ? w_diff : w_trial[32:0];
          r_dvd <= {r_dvd[QW-2:0], w_ge};
        end
        MUL: begin
          r_iax <= w_iax;
          r_iay <= w_iay;
          r_ibx <= neg32(w_iax);
          r_iby <= neg32(w_iay);
        end
        default: ;
      endcase
    end
  end

  assign imp_a_x = r_iax;
  assign imp_a_y = r_iay;
  assign imp_b_x = r_ibx;
  assign imp_b_y = r_iby;
  assign div_err = r_err;

`ifdef IMPULSE_NUDGE_EN
  logic [31:0] r_pen;
  logic [31:0] r_nax, r_nay, r_nbx, r_nby;
  logic signed [63:0] w_qx, w_qy;
  logic [31:0] w_nax, w_nay;

  assign w_qx  = $signed({32'd0, r_pen}) * $signed({{32{r_nx[31]}}, r_nx});
  assign w_qy  = $signed({32'd0, r_pen}) * $signed({{32{r_ny[31]}}, r_ny});
  assign w_nax = 32'(w_qx >>> 29);
  assign w_nay = 32'(w_qy >>> 29);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pen <= '0;
      r_nax <= '0;
      r_nay <= '0;
      r_nbx <= '0;
      r_nby <= '0;
    end else begin
      if (r_state == IDLE && in_valid)
        r_pen <= penetration;
      if (r_state == MUL) begin
        r_nax <= w_nax;
        r_nay <= w_nay;
        r_nbx <= -w_nax;
        r_nby <= -w_nay;
      end
    end
  end

  assign nudge_a_x = r_nax;
  assign nudge_a_y = r_nay;
  assign nudge_b_x = r_nbx;
  assign nudge_b_y = r_nby;
`else
  logic w_unused;
  assign w_unused  = ^penetration;
  assign nudge_a_x = '0;
  assign nudge_a_y = '0;
  assign nudge_b_x = '0;
  assign nudge_b_y = '0;
`endif

endmodule

// File: tb/tb_impulse_resolver.sv
// Bench for impulse_resolver: scoreboard of model results, monitor on the
// output handshake, directed contacts plus randomized ones.
module tb_impulse_resolver;

  localparam int DIVC = 59;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] normal_x = '0, normal_y = '0;
  logic [31:0] vrel_x = '0, vrel_y = '0;
  logic [31:0] inv_mass_a = '0, inv_mass_b = '0;
  logic [31:0] penetration = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] imp_a_x, imp_a_y, imp_b_x, imp_b_y;
  logic [31:0] nudge_a_x, nudge_a_y, nudge_b_x, nudge_b_y;
  logic        div_err;

  impulse_resolver #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .normal_x(normal_x), .normal_y(normal_y),
    .vrel_x(vrel_x), .vrel_y(vrel_y),
    .inv_mass_a(inv_mass_a), .inv_mass_b(inv_mass_b),
    .penetration(penetration),
    .out_valid(out_valid), .out_ready(out_ready),
    .imp_a_x(imp_a_x), .imp_a_y(imp_a_y),
    .imp_b_x(imp_b_x), .imp_b_y(imp_b_y),
    .nudge_a_x(nudge_a_x), .nudge_a_y(nudge_a_y),
    .nudge_b_x(nudge_b_x), .nudge_b_y(nudge_b_y),
    .div_err(div_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iax, iay, ibx, iby;
    logic [31:0] nax, nay, nbx, nby;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rnd_rdy = 0;
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic logic [31:0] satf(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return 32'(v);
  endfunction

  // reference: plain integer arithmetic on the contact rules
  function automatic exp_t model(input logic [31:0] nx, ny, vx, vy, ma, mb, pen);
    exp_t   e;
    longint vn64, den, num, qq, j;
    int     vn;
    vn64 = longint'($signed(vx)) * longint'($signed(nx))
         + longint'($signed(vy)) * longint'($signed(ny));
    vn  = int'(vn64 >>> 26);
    den = longint'(ma) + longint'(mb);
    e.err = (den == 0);
    if (vn >= 0 || den == 0) begin
      j = 0;
      e.due = 2;
    end else begin
      num = -2 * longint'(vn);
      qq  = (num <<< 26) / den;
      j   = (qq > 64'sd2147483647) ? 64'sd2147483647 : qq;
      e.due = 2 + DIVC;
    end
    e.iax = satf((j * longint'($signed(nx))) >>> 26);
    e.iay = satf((j * longint'($signed(ny))) >>> 26);
    e.ibx = (e.iax == 32'h80000000) ? 32'h7FFFFFFF : -e.iax;
    e.iby = (e.iay == 32'h80000000) ? 32'h7FFFFFFF : -e.iay;
`ifdef IMPULSE_NUDGE_EN
    e.nax = 32'((longint'(pen) * longint'($signed(nx))) >>> 29);
    e.nay = 32'((longint'(pen) * longint'($signed(ny))) >>> 29);
    e.nbx = -e.nax;
    e.nby = -e.nay;
`else
    e.nax = 0; e.nay = 0; e.nbx = 0; e.nby = 0;
    if (pen == 32'hx) e.nax = 0;
`endif
    return e;
  endfunction

  task automatic send(input logic [31:0] nx, ny, vx, vy, ma, mb, pen,
                      output int acc);
    exp_t e;
    bit   rdy;
    int   t;
    e = model(nx, ny, vx, vy, ma, mb, pen);
    normal_x = nx; normal_y = ny;
    vrel_x = vx; vrel_y = vy;
    inv_mass_a = ma; inv_mass_b = mb;
    penetration = pen;
    in_valid = 1'b1;
    t = 0;
    acc = -1;
    while (acc < 0) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = cyc;
      else if (++t > 500) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 want 1");
        acc = cyc;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    e.due += acc;
    q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: values are steady at negedge; handshake completes at the next posedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!seen) begin
          seen = 1;
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: got out_valid=1 want 0");
          end else
            chk("latency_edge", cyc, q[0].due);
        end
        if (out_ready) begin
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("imp_a_x", imp_a_x, e.iax);
            chk("imp_a_y", imp_a_y, e.iay);
            chk("imp_b_x", imp_b_x, e.ibx);
            chk("imp_b_y", imp_b_y, e.iby);
            chk("nudge_a_x", nudge_a_x, e.nax);
            chk("nudge_a_y", nudge_a_y, e.nay);
            chk("nudge_b_x", nudge_b_x, e.nbx);
            chk("nudge_b_y", nudge_b_y, e.nby);
            chk("div_err", 32'(div_err), 32'(e.err));
          end
          last.iax = imp_a_x; last.iay = imp_a_y;
          last.ibx = imp_b_x; last.iby = imp_b_y;
          last.nax = nudge_a_x; last.nbx = nudge_b_x;
          last.err = div_err;
          seen = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] rs(input int span);
    return 32'($urandom_range(0, 2 * span) - span);
  endfunction

  initial begin
    int acc;
    bit stale;
    logic [31:0] snap [0:4];
    logic [31:0] nx, ny, vx, vy, ma, mb;

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_err", 32'(div_err), 32'd0);
    chk("rst_imp_a_x", imp_a_x, 32'd0);
    chk("rst_nudge_a_x", nudge_a_x, 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // head-on
    send(32'h04000000, 0, 32'hFC000000, 0, 32'h04000000, 32'h04000000, 0, acc);
    drain();
    chk("headon_ia_x", last.iax, 32'h04000000);
    chk("headon_ib_x", last.ibx, 32'hFC000000);
    chk("headon_ia_y", last.iay, 32'h0);
    chk("headon_ib_y", last.iby, 32'h0);

    // separating
    send(32'h04000000, 0, 32'h04000000, 0, 32'h04000000, 32'h04000000, 0, acc);
    drain();
    chk("sep_ia_x", last.iax, 32'h0);
    chk("sep_ib_x", last.ibx, 32'h0);
    chk("sep_err", 32'(last.err), 32'd0);

    // zero denominator
    send(32'h04000000, 0, 32'hFC000000, 0, 0, 0, 0, acc);
    drain();
    chk("zden_ia_x", last.iax, 32'h0);
    chk("zden_err", 32'(last.err), 32'd1);

    // nudge
    send(32'h04000000, 0, 32'hFC000000, 0, 32'h04000000, 32'h04000000,
         32'h02000000, acc);
    drain();
`ifdef IMPULSE_NUDGE_EN
    chk("nudge_ax", last.nax, 32'h00400000);
    chk("nudge_bx", last.nbx, 32'hFFC00000);
`else
    chk("nudge_ax", last.nax, 32'h0);
    chk("nudge_bx", last.nbx, 32'h0);
`endif

    // backpressure
    @(posedge clk);
    #2 out_ready = 1'b0;
    send(32'h04000000, 0, 32'hFC000000, 0, 32'h04000000, 32'h04000000, 0, acc);
    for (int t = 0; t < 200 && !out_valid; t++) @(negedge clk);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    snap[0] = imp_a_x; snap[1] = imp_a_y; snap[2] = imp_b_x;
    snap[3] = imp_b_y; snap[4] = 32'(div_err);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_ax", imp_a_x, snap[0]);
      chk("bp_hold_bx", imp_b_x, snap[2]);
      chk("bp_hold_ay", imp_a_y ^ imp_b_y ^ 32'(div_err),
          snap[1] ^ snap[3] ^ snap[4]);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);

    // reset in the middle of the divide
    send(32'h04000000, 0, 32'hFC000000, 0, 32'h04000000, 32'h04000000,
         32'h02000000, acc);
    while (cyc < acc + 22) @(posedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    seen = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err", 32'(div_err), 32'd0);
    chk("mid_rst_ia_x", imp_a_x, 32'd0);
    chk("mid_rst_ib_x", imp_b_x, 32'd0);
    chk("mid_rst_na_x", nudge_a_x, 32'd0);
    #10 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    chk("no_stale_result", 32'(stale), 32'd0);
    @(posedge clk);
    #1;

    // randomized contacts with random backpressure
    rnd_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        nx = $urandom; ny = $urandom; vx = $urandom; vy = $urandom;
      end else begin
        nx = rs(32'h04000000); ny = rs(32'h04000000);
        vx = rs(32'h10000000); vy = rs(32'h10000000);
      end
      case ($urandom_range(0, 5))
        0: begin ma = 0; mb = 0; end
        1: begin ma = $urandom; mb = $urandom; end
        2: begin ma = $urandom_range(0, 255); mb = 0; end
        default: begin
          ma = $urandom_range(0, 32'h10000000);
          mb = $urandom_range(0, 32'h10000000);
        end
      endcase
      send(nx, ny, vx, vy, ma, mb, $urandom, acc);
    end
    drain();
    rnd_rdy = 0;
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
